// File: rtl/snn_pkg.sv
// Shared types and the saturation helper for the time-multiplexed synapse scheduler.
package snn_pkg;

    localparam int SNN_W = 18;

    typedef logic signed [SNN_W-1:0] current_t;
    typedef logic signed [SNN_W-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic     ovf;
        current_t val;
    } sat_res_t;

    // The value fits only when every bit above the W-bit sign bit repeats that sign bit.
    function automatic sat_res_t sat_w(input logic signed [SNN_W+2:0] x);
        sat_res_t res;
        if ((x[SNN_W+2:SNN_W-1] == '0) || (x[SNN_W+2:SNN_W-1] == '1)) begin
            res.ovf = 1'b0;
            res.val = x[SNN_W-1:0];
        end else begin
            res.ovf = 1'b1;
            res.val = x[SNN_W+2] ? {1'b1, {(SNN_W-1){1'b0}}} : {1'b0, {(SNN_W-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/synapse_update_dp.sv
// Combinational leak, weighted spike sum and saturation for one synapse.
module synapse_update_dp
    import snn_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int W          = SNN_W,
    parameter int LEAK_SHIFT = 4
) (
    input  logic signed [W-1:0]      v_i,
    input  logic        [N_IN*W-1:0] weights_i,
    input  logic        [N_IN-1:0]   spikes_i,
    output logic signed [W-1:0]      vnew_o,
    output logic                     sat_o
);

    logic signed [W+2:0] acc;
    sat_res_t            res;

    // Three guard bits cover the worst case of a full-scale current plus N_IN full-scale weights.
    always_comb begin
        acc = (W+3)'(v_i) - (W+3)'(v_i >>> LEAK_SHIFT);
        for (int j = 0; j < N_IN; j++) begin
            if (spikes_i[j]) begin
                acc = acc + (W+3)'($signed(weights_i[j*W +: W]));
            end
        end
        res    = sat_w(acc);
        vnew_o = res.val;
        sat_o  = res.ovf;
    end

endmodule

// File: rtl/synapse_scheduler.sv
// Walks all synapses once per timestep tick through a single shared update datapath
// and streams the refreshed currents to the membrane integrators.
module synapse_scheduler
    import snn_pkg::*;
#(
    parameter int N_SYN      = 8,
    parameter int N_IN       = 3,
    parameter int W          = SNN_W,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [N_SYN*N_IN-1:0]      spike_in,
    input  logic                       cfg_we,
    input  logic [$clog2(N_SYN)-1:0]   cfg_syn,
    input  logic [$clog2(N_IN)-1:0]    cfg_in,
    input  logic signed [W-1:0]        cfg_weight,
    output logic                       cfg_ready,
    output logic                       busy,
    output logic                       cur_valid,
    output logic [$clog2(N_SYN)-1:0]   cur_idx,
    output logic signed [W-1:0]        cur_data,
    output logic                       done,
    input  logic                       err_clr,
    output logic                       sat_flag,
    output logic                       err_flag
);

    localparam int IW = $clog2(N_SYN);

    sched_state_t          state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [N_SYN*N_IN-1:0] spk_q;
    logic signed [W-1:0]   v_q [N_SYN];
    logic signed [W-1:0]   w_q [N_SYN][N_IN];
    logic                  curValid_q;
    logic [IW-1:0]         curIdx_q;
    logic signed [W-1:0]   curData_q;
    logic                  satFlag_q;
    logic                  errFlag_q;

    logic                  isIdle;
    logic                  cfgInRange;
    logic                  cfgAccept;
    logic                  errSet;
    logic                  satSet;
    logic [N_IN*W-1:0]     dpWeights;
    logic [N_IN-1:0]       dpSpikes;
    logic signed [W-1:0]   dpVnew;
    logic                  dpSat;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (idx_q == IW'(N_SYN-1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Weight writes only land while idle; anything else is dropped and flagged.
    always_comb begin
        isIdle     = (state_q == IDLE);
        cfgInRange = (int'(cfg_syn) < N_SYN) && (int'(cfg_in) < N_IN);
        cfgAccept  = cfg_we && isIdle && cfgInRange;
        errSet     = (tick && !isIdle) || (cfg_we && !(isIdle && cfgInRange));
        satSet     = (state_q == UPDATE) && dpSat;
        dpWeights  = '0;
        for (int j = 0; j < N_IN; j++) begin
            dpWeights[j*W +: W] = w_q[idx_q][j];
        end
        dpSpikes = spk_q[int'(idx_q)*N_IN +: N_IN];
    end

    synapse_update_dp #(
        .N_IN      (N_IN),
        .W         (W),
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_dp (
        .v_i      (v_q[idx_q]),
        .weights_i(dpWeights),
        .spikes_i (dpSpikes),
        .vnew_o   (dpVnew),
        .sat_o    (dpSat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            spk_q      <= '0;
            curValid_q <= 1'b0;
            curIdx_q   <= '0;
            curData_q  <= '0;
            satFlag_q  <= 1'b0;
            errFlag_q  <= 1'b0;
            for (int k = 0; k < N_SYN; k++) begin
                v_q[k] <= '0;
                for (int j = 0; j < N_IN; j++) begin
                    w_q[k][j] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            curValid_q <= (state_q == UPDATE);
            if (isIdle && tick) begin
                spk_q <= spike_in;
            end
            if (cfgAccept) begin
                w_q[cfg_syn][cfg_in] <= cfg_weight;
            end
            if (state_q == UPDATE) begin
                v_q[idx_q] <= dpVnew;
                curIdx_q   <= idx_q;
                curData_q  <= dpVnew;
            end
            // A clear and a new event in the same cycle leave the flag set.
            satFlag_q <= (err_clr ? 1'b0 : satFlag_q) | satSet;
            errFlag_q <= (err_clr ? 1'b0 : errFlag_q) | errSet;
        end
    end

    assign cfg_ready = isIdle;
    assign busy      = !isIdle;
    assign done      = (state_q == DONE);
    assign cur_valid = curValid_q;
    assign cur_idx   = curIdx_q;
    assign cur_data  = curData_q;
    assign sat_flag  = satFlag_q;
    assign err_flag  = errFlag_q;

endmodule
